// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with incrementer, branch/jump redirect
// and a circular return-address stack for call/return.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter int               SHIFT        = 2,
  parameter int               ALIGN_BITS   = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] FAULT_VECTOR = 32'h0000_0080,
  parameter int               DEPTH        = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Call,
  input  logic             Ret,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCAddResult,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasUnderflow,
  output logic             MisalignFault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             r_uf;
  logic             r_mf;

  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_next_pc;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_ptr_dec;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_redirect;
  logic             w_uf;
  logic             w_mf;

  assign w_add    = r_pc + WIDTH'(STEP);
  assign w_br_tgt = w_add + (BranchOffset << SHIFT);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));

  // ptr names the next free slot; top of stack sits one below it
  assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign w_ptr_dec = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - 1'b1;

  always_comb begin
    w_next_pc  = w_add;
    w_tgt      = w_add;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_redirect = 1'b0;
    w_uf       = 1'b0;
    if (Stall) begin
      w_next_pc = r_pc;
    end else if (Ret) begin
      if (!w_empty) begin
        w_pop      = 1'b1;
        w_redirect = 1'b1;
        w_tgt      = r_ras[w_ptr_dec];
      end else begin
        w_uf = 1'b1;
      end
    end else if (Jump) begin
      w_redirect = 1'b1;
      w_tgt      = JumpTarget;
      w_push     = Call;
    end else if (BranchTaken) begin
      w_redirect = 1'b1;
      w_tgt      = w_br_tgt;
    end
    w_mf = w_redirect && ((w_tgt & ALIGN_MASK) != '0);
    if (w_redirect) begin
      w_next_pc = w_mf ? FAULT_VECTOR : w_tgt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc    <= RESET_VECTOR;
      r_ptr   <= '0;
      r_count <= '0;
      r_uf    <= 1'b0;
      r_mf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else begin
      r_pc <= w_next_pc;
      r_uf <= w_uf;
      r_mf <= w_mf;
      if (w_push) begin
        r_ras[r_ptr] <= w_add;
        r_ptr        <= w_ptr_inc;
        if (!w_full) begin
          r_count <= r_count + 1'b1;
        end
      end else if (w_pop) begin
        r_ptr   <= w_ptr_dec;
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign PCResult      = r_pc;
  assign PCAddResult   = w_add;
  assign RasEmpty      = w_empty;
  assign RasFull       = w_full;
  assign RasUnderflow  = r_uf;
  assign MisalignFault = r_mf;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the instruction fetch stage. Merges the PC register and the PC incrementer into one block.
- Adds stall, relative branch, absolute jump and call/return redirection.
- Call/return targets come from a DEPTH-entry circular return-address stack (RAS).
- Feeds the instruction memory address and exports PC+STEP for link/branch-base use downstream.

Parameters:
- WIDTH, 32: PC and address width in bits.
- STEP, 4: sequential increment per fetch.
- SHIFT, 2: left shift applied to BranchOffset (word to byte).
- ALIGN_BITS, 2: number of low PC bits that must be zero.
- RESET_VECTOR, 32'h0000_0000: PC value on reset.
- FAULT_VECTOR, 32'h0000_0080: PC loaded on a misaligned redirect.
- DEPTH, 4: RAS entries; must be at least 2.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold PC and RAS this cycle
- BranchTaken  in  1  take relative branch
- BranchOffset  in  WIDTH  signed offset, pre-shift
- Jump  in  1  take absolute jump
- JumpTarget  in  WIDTH  absolute jump target
- Call  in  1  with Jump: push PCAddResult onto RAS
- Ret  in  1  pop RAS and redirect to the popped value
- PCResult  out  WIDTH  current PC (registered)
- PCAddResult  out  WIDTH  PCResult+STEP (combinational)
- RasEmpty  out  1  RAS count == 0
- RasFull  out  1  RAS count == DEPTH
- RasUnderflow  out  1  one-cycle pulse: Ret issued on empty RAS
- MisalignFault  out  1  one-cycle pulse: redirect target misaligned

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; it overrides all inputs at any time, including mid-stall or mid-redirect.
- Reset values: PCResult=RESET_VECTOR; RAS count=0, pointer=0, entries=0; RasEmpty=1; RasFull=0; RasUnderflow=0; MisalignFault=0.
- Arithmetic: all PC arithmetic is modulo 2^WIDTH; wrap-around is silent. 'hFFFFFFFC+4 = 0.
- Branch target: PCAddResult + (sign-extended BranchOffset << SHIFT).
- Next-PC priority per clock edge (one-cycle latency; PCResult updates on the edge):
  1. Stall=1: PC, RAS and count hold. All other inputs are ignored. Fault and underflow pulses are 0.
  2. Ret=1: if the RAS is non-empty, pop and PC = popped entry. If empty, PC = PCAddResult and RasUnderflow=1 next cycle. Jump, Call and BranchTaken are ignored.
  3. Jump=1: PC = JumpTarget. If Call=1, also push PCAddResult.
  4. BranchTaken=1: PC = branch target.
  5. Otherwise: PC = PCAddResult.
- Call without Jump: ignored.
- RAS push when full: overwrites the oldest entry (circular). Pointer advances, count stays DEPTH, RasFull stays 1.
- RAS pop: decrements the pointer modulo DEPTH and decrements the count.
- Misalignment check: applies to the selected redirect target only (Ret, Jump or Branch), and only on its low ALIGN_BITS.
  - If nonzero: PC = FAULT_VECTOR and MisalignFault=1 for the next cycle.
  - RAS side effects of that cycle (push or pop) still occur.
- Pulse outputs: RasUnderflow and MisalignFault are registered and high for exactly one cycle per event.
- Status outputs: RasEmpty and RasFull are registered-derived from the count.

Test Plan:
- Reset asserted asynchronously between edges -> PCResult=0 immediately, RasEmpty=1. Release, 3 free-running edges -> PCResult 4, 8, 12; PCAddResult always PCResult+4.
- Wrap: with PCResult='hFFFFFFF8, apply 2 edges -> PCResult 'hFFFFFFFC, then 0.
- At PC=0x100, Stall=1 for 2 cycles with BranchTaken=1 -> PC holds 0x100. Then Stall=0, BranchTaken=1, BranchOffset=-2 -> PC=0x0FC (0x104-8).
- At PC=0x200, Jump+Call, JumpTarget=0x400 -> PC=0x400, RasEmpty=0. Next cycle Ret -> PC=0x204, RasEmpty=1. Another Ret -> PC=0x208, RasUnderflow pulses once.
- Five Jump+Call pushes from PCs 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH=4) -> RasFull=1. Four Rets return 0x54, 0x44, 0x34, 0x24, then RasEmpty=1 (0x14 overwritten).
- Jump with JumpTarget=0x402 -> PC=FAULT_VECTOR (0x80), MisalignFault=1 for exactly one cycle. Same-cycle Ret+Jump -> Ret wins.
